// File: rtl/core_pkg.sv
// Shared core types and constants used by the MEM-stage load/store unit.
package core_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_REQ,
    MS_WAIT_RSP,
    MS_DONE
  } mem_state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] rd_data2;
    logic [2:0]            funct3;
    logic                  mem_read;
    logic                  mem_write;
  } ex_mem_data_t;

endpackage

// File: rtl/EX2MEM_if.sv
// EX/MEM pipeline register bus; the MEM stage is the consumer.
interface EX2MEM_if;
  import core_pkg::*;

  ex_mem_data_t data;

  modport MASTER (output data);
  modport SLAVE  (input  data);
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, extraction/extension for loads, and legality check.
module lsu_align
  import core_pkg::*;
(
  input  logic [2:0]            i_funct3,
  input  logic [1:0]            i_addr_lo,
  input  logic                  i_is_store,
  input  logic [DATA_WIDTH-1:0] i_st_data,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic [3:0]            o_be,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic [DATA_WIDTH-1:0] o_ld_data,
  output logic                  o_illegal
);

  logic [DATA_WIDTH-1:0] w_shifted;
  assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

  always_comb begin
    o_be      = 4'b1111;
    o_wdata   = i_st_data;
    o_ld_data = w_shifted;
    o_illegal = 1'b0;
    case (i_funct3)
      F3_B: begin
        if (i_is_store) o_be = 4'b0001 << i_addr_lo;
        o_wdata   = {4{i_st_data[7:0]}};
        o_ld_data = {{(DATA_WIDTH-8){w_shifted[7]}}, w_shifted[7:0]};
      end
      F3_H: begin
        if (i_is_store) o_be = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata   = {2{i_st_data[15:0]}};
        o_ld_data = {{(DATA_WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
        o_illegal = i_addr_lo[0];
      end
      F3_W: o_illegal = |i_addr_lo;
      // Unsigned variants only exist for loads
      F3_BU: begin
        o_ld_data = {{(DATA_WIDTH-8){1'b0}}, w_shifted[7:0]};
        o_illegal = i_is_store;
      end
      F3_HU: begin
        o_ld_data = {{(DATA_WIDTH-16){1'b0}}, w_shifted[15:0]};
        o_illegal = i_is_store | i_addr_lo[0];
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: req/gnt/rvalid handshake to data memory with
// pipeline stall, response timeout and registered load result.
module mem_access_unit
  import core_pkg::*;
#(
  parameter int RSP_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  EX2MEM_if.SLAVE               bus_in,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [DATA_WIDTH-1:0] dmem_addr_o,
  output logic [3:0]            dmem_be_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
  output logic                  stall_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  load_valid_o,
  output logic                  err_misalign_o,
  output logic                  err_timeout_o
);

  localparam int CW = $clog2(RSP_TIMEOUT + 1);

  mem_state_e            r_state, w_next;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_mem_data;
  logic                  r_timed_out;

  ex_mem_data_t          w_in;
  logic                  w_access, w_is_store, w_illegal, w_busy, w_timeout;
  logic                  w_req, w_stall, w_err_mis, w_err_to;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata, w_ld_data;

  assign w_in       = bus_in.data;
  assign w_access   = w_in.mem_read | w_in.mem_write;
  assign w_is_store = w_in.mem_write;
  assign w_busy     = (r_state == MS_REQ) || (r_state == MS_WAIT_RSP);
  assign w_timeout  = w_busy && (r_cnt == CW'(RSP_TIMEOUT));

  lsu_align u_align (
    .i_funct3   (w_in.funct3),
    .i_addr_lo  (w_in.alu_result[1:0]),
    .i_is_store (w_is_store),
    .i_st_data  (w_in.rd_data2),
    .i_rdata    (dmem_rdata_i),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_ld_data  (w_ld_data),
    .o_illegal  (w_illegal)
  );

  always_comb begin
    w_next    = r_state;
    w_req     = 1'b0;
    w_stall   = 1'b0;
    w_err_mis = 1'b0;
    w_err_to  = 1'b0;
    case (r_state)
      MS_IDLE: begin
        if (w_access) begin
          if (w_illegal) begin
            w_err_mis = 1'b1;
          end else begin
            w_req   = 1'b1;
            w_stall = 1'b1;
            if (dmem_gnt_i) w_next = w_is_store ? MS_DONE : MS_WAIT_RSP;
            else            w_next = MS_REQ;
          end
        end
      end
      MS_REQ: begin
        w_stall = 1'b1;
        if (w_timeout) begin
          w_err_to = 1'b1;
          w_next   = MS_DONE;
        end else begin
          w_req = 1'b1;
          if (dmem_gnt_i) w_next = w_is_store ? MS_DONE : MS_WAIT_RSP;
        end
      end
      MS_WAIT_RSP: begin
        w_stall = 1'b1;
        if (w_timeout) begin
          w_err_to = 1'b1;
          w_next   = MS_DONE;
        end else if (dmem_rvalid_i) begin
          w_next = MS_DONE;
        end
      end
      default: w_next = MS_IDLE;
    endcase
    // Hold every output quiet while reset is applied, whatever the bus carries
    if (rst) begin
      w_req     = 1'b0;
      w_stall   = 1'b0;
      w_err_mis = 1'b0;
      w_err_to  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= MS_IDLE;
      r_cnt       <= '0;
      r_mem_data  <= '0;
      r_timed_out <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_busy ? r_cnt + CW'(1) : '0;
      r_timed_out <= w_timeout;
      if (w_timeout)
        r_mem_data <= '0;
      else if (r_state == MS_WAIT_RSP && dmem_rvalid_i)
        r_mem_data <= w_ld_data;
    end
  end

  assign dmem_req_o     = w_req;
  assign dmem_we_o      = w_req & w_is_store;
  assign dmem_addr_o    = w_req ? {w_in.alu_result[DATA_WIDTH-1:2], 2'b00} : '0;
  assign dmem_be_o      = w_req ? w_be : 4'b0000;
  assign dmem_wdata_o   = (w_req & w_is_store) ? w_wdata : '0;
  assign stall_o        = w_stall;
  assign mem_data_o     = r_mem_data;
  // A timed-out load ends in DONE with zero data but is not reported as valid
  assign load_valid_o   = !rst && (r_state == MS_DONE) && w_in.mem_read &&
                          !w_in.mem_write && !r_timed_out;
  assign err_misalign_o = w_err_mis;
  assign err_timeout_o  = w_err_to;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed + random checks of mem_access_unit against a byte-level memory access model.
module tb_mem_access_unit;
  import core_pkg::*;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        dmem_req_o, dmem_we_o, dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i, mem_data_o;
  logic [3:0]  dmem_be_o;
  logic        stall_o, load_valid_o, err_misalign_o, err_timeout_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_mem;
  logic [31:0] last_md;

  EX2MEM_if bus();

  mem_access_unit #(.RSP_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .bus_in(bus),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .stall_o(stall_o),
    .mem_data_o(mem_data_o), .load_valid_o(load_valid_o),
    .err_misalign_o(err_misalign_o), .err_timeout_o(err_timeout_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus.data      = '0;
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
  endtask

  // One access from IDLE to completion. gd = cycle index of gnt (0 = first
  // request cycle), rd = cycles from gnt to rvalid. Called just after a posedge.
  task automatic do_access(input string tag, input logic [2:0] f3, input logic st,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rdata, input int gd, input int rd);
    int n, stall_n, req_n, to_n, mis_n, exp_stall, exp_req;
    bit legal, ok, done, got, unstable;
    logic [3:0]  exp_be, be0;
    logic [31:0] exp_wd, exp_ld, v, mask, a0, w0, lv;
    logic        we0;
    n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) && !(st && f3[2]) &&
            ((addr % n) == 0);
    exp_be = st ? 4'(((1 << n) - 1) << (addr % 4)) : 4'hF;
    for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wd[8*(i % n) +: 8];
    mask   = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*n)) - 1);
    v      = (rdata >> (8 * (addr % 4))) & mask;
    exp_ld = (!f3[2] && n < 4 && v[8*n-1]) ? (v | ~mask) : v;
    ok        = st ? (gd <= T) : (gd + rd <= T);
    exp_stall = !legal ? 0 : ok ? (st ? gd + 1 : gd + rd + 1) : T + 2;
    exp_req   = !legal ? 0 : ((gd <= T) ? gd : T) + 1;

    bus.data = '{alu_result: addr, rd_data2: wd, funct3: f3,
                 mem_read: !st, mem_write: st};
    dmem_rdata_i = rdata;
    stall_n = 0; req_n = 0; to_n = 0; mis_n = 0;
    done = 0; got = 0; unstable = 0; lv = 'x; last_md = 'x;
    a0 = '0; w0 = '0; be0 = '0; we0 = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      dmem_gnt_i    = (k == gd);
      dmem_rvalid_i = !st && (k == gd + rd);
      @(negedge clk);
      if (dmem_req_o) begin
        req_n++;
        if (!got) begin
          a0 = dmem_addr_o; be0 = dmem_be_o; w0 = dmem_wdata_o; we0 = dmem_we_o; got = 1;
        end else if (dmem_addr_o !== a0 || dmem_be_o !== be0 ||
                     dmem_wdata_o !== w0 || dmem_we_o !== we0) unstable = 1;
      end
      if (err_timeout_o)  to_n++;
      if (err_misalign_o) mis_n++;
      if (stall_o) stall_n++;
      else begin
        done = 1; lv = {31'd0, load_valid_o}; last_md = mem_data_o;
      end
      @(posedge clk); #1;
    end
    bus_idle();

    if (legal) model_mem = ok ? (st ? model_mem : exp_ld) : 32'd0;
    chk({tag, " finished"}, {31'd0, done}, 32'd1);
    chk({tag, " stall_cycles"}, stall_n, exp_stall);
    chk({tag, " req_cycles"}, req_n, exp_req);
    chk({tag, " misalign"}, mis_n, legal ? 0 : 1);
    chk({tag, " timeout"}, to_n, (legal && !ok) ? 1 : 0);
    chk({tag, " req_stable"}, {31'd0, unstable}, 32'd0);
    chk({tag, " load_valid"}, lv, {31'd0, legal && ok && !st});
    chk({tag, " mem_data"}, last_md, model_mem);
    if (got) begin
      chk({tag, " addr"}, a0, {addr[31:2], 2'b00});
      chk({tag, " we"}, {31'd0, we0}, {31'd0, st});
      chk({tag, " be"}, {28'd0, be0}, {28'd0, exp_be});
      if (st) chk({tag, " wdata"}, w0, exp_wd);
    end
  endtask

  initial begin
    bus_idle();
    dmem_rdata_i = '0;
    model_mem = '0;
    last_md = '0;
    rst = 1'b1;
    bus.data = '{alu_result: 32'h100, rd_data2: 32'h1, funct3: F3_W,
                 mem_read: 1'b1, mem_write: 1'b0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset req", {31'd0, dmem_req_o}, 32'd0);
    chk("reset stall", {31'd0, stall_o}, 32'd0);
    chk("reset mem_data", mem_data_o, 32'd0);
    chk("reset lv_err", {29'd0, load_valid_o, err_misalign_o, err_timeout_o}, 32'd0);
    chk("reset bus", dmem_addr_o | dmem_wdata_o | {28'd0, dmem_be_o}, 32'd0);
    bus_idle();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    do_access("sw",  F3_W,  1'b1, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1);
    do_access("sb",  F3_B,  1'b1, 32'h102, 32'h000000AB, 32'h0, 0, 1);
    do_access("lb",  F3_B,  1'b0, 32'h103, 32'h0, 32'h80123456, 2, 3);
    chk("lb const", last_md, 32'hFFFFFF80);
    do_access("lhu", F3_HU, 1'b0, 32'h102, 32'h0, 32'hBEEF1234, 0, 1);
    chk("lhu const", last_md, 32'h0000BEEF);
    do_access("lh",  F3_H,  1'b0, 32'h102, 32'h0, 32'h7EEF1234, 1, 1);
    chk("lh const", last_md, 32'h00007EEF);
    do_access("sh_mis", F3_H, 1'b1, 32'h101, 32'h1234, 32'h0, 0, 1);
    do_access("f3_011", 3'b011, 1'b0, 32'h100, 32'h0, 32'h0, 0, 1);
    do_access("lw_to",  F3_W, 1'b0, 32'h200, 32'h0, 32'h55AA55AA, 0, 100);
    chk("lw_to const", last_md, 32'h0);
    do_access("sw_edge", F3_W, 1'b1, 32'h204, 32'h01020304, 32'h0, T, 1);
    do_access("lw_edge", F3_W, 1'b0, 32'h208, 32'h0, 32'hCAFEF00D, 3, T - 3);

    for (int it = 0; it < 40; it++) begin
      int gd, rd;
      gd = ($urandom_range(0, 7) == 0) ? int'($urandom_range(5, 12)) : int'($urandom_range(0, 3));
      rd = $urandom_range(1, 4);
      do_access("rand", 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                $urandom, $urandom, $urandom, gd, rd);
    end

    // Reset while waiting for a load response; the late rvalid must be dropped
    do_access("pre_rst", F3_W, 1'b0, 32'h300, 32'h0, 32'h11223344, 0, 1);
    bus.data = '{alu_result: 32'h300, rd_data2: 32'h0, funct3: F3_W,
                 mem_read: 1'b1, mem_write: 1'b0};
    dmem_rdata_i = 32'h99887766;
    dmem_gnt_i = 1'b1;
    @(negedge clk);
    chk("rst_run req", {31'd0, dmem_req_o}, 32'd1);
    @(posedge clk); #1;
    dmem_gnt_i = 1'b0;
    @(negedge clk);
    chk("rst_run wait stall", {30'd0, stall_o, dmem_req_o}, 32'd2);
    @(posedge clk); #1;
    rst = 1'b1;
    bus_idle();
    @(posedge clk); #1;
    rst = 1'b0;
    dmem_rvalid_i = 1'b1;
    @(negedge clk);
    chk("rst_run state", 32'(dut.r_state), 32'(MS_IDLE));
    chk("rst_run outs", {28'd0, dmem_req_o, stall_o, load_valid_o, err_timeout_o}, 32'd0);
    chk("rst_run mem_data", mem_data_o, 32'd0);
    @(posedge clk); #1;
    dmem_rvalid_i = 1'b0;
    @(negedge clk);
    chk("rst_run late rvalid", {29'd0, load_valid_o, stall_o, dmem_req_o}, 32'd0);
    chk("rst_run mem_data2", mem_data_o, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store engine. It is the consumer end of the EX2MEM bus.
- Takes alu_result (address), rd_data2 (store data), funct3, MemRead and MemWrite from the EX/MEM register.
- Runs a req/gnt/rvalid handshake to data memory and stalls the pipeline until the access completes.
- Returns the aligned, extended load data. That data is both the MEM forwarding source and the WB load value.

Parameters:
- DATA_WIDTH, 32, data and address width from core_pkg.
- RSP_TIMEOUT, 64, maximum cycles spent in REQ or WAIT_RSP before the access is aborted.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- bus_in  input  EX2MEM_if.SLAVE  carries ex_mem_data_t. Upstream holds it stable while stall_o=1.
- dmem_req_o  output  1  request valid.
- dmem_we_o  output  1  1=store, 0=load.
- dmem_addr_o  output  DATA_WIDTH  word address, {alu_result[31:2],2'b00}.
- dmem_be_o  output  4  byte enables.
- dmem_wdata_o  output  DATA_WIDTH  lane-replicated store data.
- dmem_gnt_i  input  1  request accepted this cycle.
- dmem_rvalid_i  input  1  load response valid.
- dmem_rdata_i  input  DATA_WIDTH  raw load word.
- stall_o  output  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- mem_data_o  output  DATA_WIDTH  extended load result, registered.
- load_valid_o  output  1  mem_data_o is valid this cycle.
- err_misalign_o  output  1  one-cycle pulse: misaligned address or reserved funct3.
- err_timeout_o  output  1  one-cycle pulse: RSP_TIMEOUT expired.

Behaviour:
- Reset values: all outputs 0. State goes to IDLE, timeout counter cleared.
- Reset in any state: IDLE on the next cycle and dmem_req_o drops. A late rvalid arriving in IDLE is ignored.
- States and transitions:
  - IDLE:
    - access = MemRead|MemWrite.
    - If access is legal: dmem_req_o=1 and stall_o=1 combinationally in the same cycle.
    - If gnt is seen in that cycle: a store goes to DONE, a load goes to WAIT_RSP. Without gnt, go to REQ.
    - If access is illegal: no request, no stall, err_misalign_o=1 for that cycle, stay in IDLE.
  - REQ:
    - req, we, addr, be and wdata are held stable and stall_o=1.
    - On gnt: a store goes to DONE, a load goes to WAIT_RSP.
    - rvalid in this state is ignored.
  - WAIT_RSP:
    - req=0, stall_o=1.
    - On rvalid: capture the extended data into mem_data_o and go to DONE.
    - gnt in this state is ignored.
  - DONE:
    - stall_o=0, so the pipeline advances at the end of this cycle.
    - load_valid_o=1 for loads.
    - Next state is IDLE, which sees the next instruction.
- Timeout:
  - The counter increments each cycle in REQ or WAIT_RSP and clears on entering IDLE.
  - When it reaches RSP_TIMEOUT: err_timeout_o pulses, req drops, mem_data_o=0, and the state goes to DONE.
- Latency with zero-wait memory:
  - Store: stall for 1 cycle (IDLE), release in DONE.
  - Load: gnt in IDLE, rvalid the cycle after; stall for 2 cycles, data valid in DONE.
- funct3 decode (instruction[14:12]):
  - 000 B, 001 H, 010 W, 100 BU, 101 HU.
  - BU and HU are legal for loads only. 011, 110 and 111 are reserved and treated as illegal.
- Alignment rules:
  - H is illegal if addr[0]=1.
  - W is illegal if addr[1:0]!=0.
- Store lanes:
  - SB: be=4'b0001<<addr[1:0], wdata={4{rd_data2[7:0]}}.
  - SH: be=4'b0011<<{addr[1],1'b0}, wdata={2{rd_data2[15:0]}}.
  - SW: be=4'b1111.
- Load extraction:
  - Shift: rdata>>(8*addr[1:0]).
  - B and H are sign-extended; BU and HU are zero-extended. Loads drive be=4'b1111.
- mem_data_o holds its value until the next load completes.

Decomposition:
- core_pkg gains:
  - mem_state_e {MS_IDLE, MS_REQ, MS_WAIT_RSP, MS_DONE}.
  - F3_B, F3_H, F3_W, F3_BU, F3_HU localparams.
- One combinational sub-module, lsu_align:
  - Inputs: funct3, addr[1:0], store data, raw rdata.
  - Outputs: be, wdata, extended load data, illegal flag.
- The FSM, timeout counter and output registers stay in mem_access_unit.

Test Plan:
- SW 0xDEADBEEF to 0x100, gnt in the same cycle:
  - Expect req for 1 cycle, addr 0x100, be 1111, wdata 0xDEADBEEF, we=1.
  - Expect stall high for 1 cycle, DONE the next cycle.
- SB 0x000000AB to 0x102:
  - Expect be 0100, wdata 0xABABABAB, addr 0x100.
- LB from 0x103, gnt delayed 2 cycles, rvalid 3 cycles after gnt, rdata 0x80123456:
  - Expect req held stable for 3 cycles and stall high for 6 cycles.
  - Expect mem_data_o=0xFFFFFF80 with load_valid_o in DONE.
- LHU from 0x102, rdata 0xBEEF1234:
  - Expect mem_data_o=0x0000BEEF.
  - LH from 0x102 with rdata 0x7EEF1234 gives 0x00007EEF.
- Illegal accesses:
  - SH to 0x101: err_misalign_o for 1 cycle, no req, stall_o=0.
  - Load with funct3=011: same response.
- Timeout and reset:
  - RSP_TIMEOUT=8, load granted, no rvalid: err_timeout_o pulses after 8 cycles, mem_data_o=0, stall releases in DONE.
  - Second run: assert rst in WAIT_RSP, then send rvalid. Expect state IDLE, no load_valid_o, all outputs 0.
